// File: rtl/ysyx_23060124_mdu_pkg.sv
// Shared opcode (funct3), FSM state and counter-width definitions for the MDU.
// Combinational only; no timing or handshake of its own.
package ysyx_23060124_mdu_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Iteration counter width for a given operand width.
   function automatic int cnt_width(input int xlen);
      return $clog2(xlen);
   endfunction

endpackage

// File: rtl/ysyx_23060124_mdu_divstep.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational; no latency and no handshake.
module ysyx_23060124_mdu_divstep #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem,
   input  logic            dvd_bit,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic            q_bit
);

   logic [XLEN:0] shifted;

   always_comb begin
      shifted  = {rem, dvd_bit};
      q_bit    = (shifted >= {1'b0, divisor});
      // rem < divisor on entry, so a successful subtraction always fits XLEN bits
      rem_next = q_bit ? XLEN'(shifted - {1'b0, divisor}) : shifted[XLEN-1:0];
   end

endmodule

// File: rtl/ysyx_23060124_mdu.sv
// RV M-extension mul/div unit, one bit per cycle; YSYX_23060124_MDU_FASTMUL_EN selects a one-cycle multiplier.
// Result XLEN+1 cycles after accept (1 for div-by-zero/overflow, 2 for fast MUL); held until out_ready, no accept while busy.
module ysyx_23060124_mdu
   import ysyx_23060124_mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic [2:0]      opt,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] res
);

   localparam int CW = cnt_width(XLEN);

   logic [1:0]      state;
   logic [CW-1:0]   cnt;
   logic [2:0]      opt_q;
   logic            neg_q;
   logic            neg_r;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] acc_hi;
   logic [XLEN-1:0] acc_lo;
   logic [XLEN-1:0] res_q;

   logic            s1_signed, s2_signed, s1_neg, s2_neg;
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] mag1, mag2, most_neg;

   logic [XLEN:0]     mul_add;
   logic [XLEN-1:0]   mul_hi_n, mul_lo_n;
   logic [XLEN-1:0]   div_rem_n, div_q_n;
   logic              div_qbit;
   logic [2*XLEN-1:0] prod_raw, prod_fix;
   logic [XLEN-1:0]   mul_res, div_res, step_res;
   logic              fast_mul;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign res       = res_q;

   always_comb begin
      s1_signed = (opt != OP_MULHU) && (opt != OP_DIVU) && (opt != OP_REMU);
      s2_signed = (opt == OP_MUL) || (opt == OP_MULH) || (opt == OP_DIV) || (opt == OP_REM);
      s1_neg    = s1_signed && src1[XLEN-1];
      s2_neg    = s2_signed && src2[XLEN-1];
      mag1      = s1_neg ? -src1 : src1;
      mag2      = s2_neg ? -src2 : src2;
      most_neg  = {1'b1, {(XLEN-1){1'b0}}};
      div_zero  = opt[2] && (src2 == '0);
      div_ovf   = ((opt == OP_DIV) || (opt == OP_REM)) && (src1 == most_neg) && (src2 == '1);
   end

   // Multiply: {acc_hi, acc_lo} is the product register, multiplier consumed from acc_lo[0].
   always_comb begin
      mul_add  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : {(XLEN+1){1'b0}});
      mul_hi_n = mul_add[XLEN:1];
      mul_lo_n = {mul_add[0], acc_lo[XLEN-1:1]};
   end

   // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
   ysyx_23060124_mdu_divstep #(.XLEN(XLEN)) u_divstep (
      .rem      (acc_hi),
      .dvd_bit  (acc_lo[XLEN-1]),
      .divisor  (op_a),
      .rem_next (div_rem_n),
      .q_bit    (div_qbit)
   );

   assign div_q_n = {acc_lo[XLEN-2:0], div_qbit};

`ifdef YSYX_23060124_MDU_FASTMUL_EN
   assign fast_mul = ~opt_q[2];
   assign prod_raw = {{XLEN{1'b0}}, op_a} * {{XLEN{1'b0}}, acc_lo};
`else
   assign fast_mul = 1'b0;
   assign prod_raw = {mul_hi_n, mul_lo_n};
`endif

   always_comb begin
      prod_fix = neg_q ? -prod_raw : prod_raw;
      mul_res  = (opt_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      if (opt_q[1])
         div_res = neg_r ? -div_rem_n : div_rem_n;
      else
         div_res = neg_q ? -div_q_n : div_q_n;
      step_res = opt_q[2] ? div_res : mul_res;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         opt_q  <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         op_a   <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         res_q  <= '0;
      end else if (flush) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  opt_q  <= opt;
                  neg_q  <= s1_neg ^ s2_neg;
                  neg_r  <= s1_neg;
                  cnt    <= '0;
                  acc_hi <= '0;
                  op_a   <= opt[2] ? mag2 : mag1;
                  acc_lo <= opt[2] ? mag1 : mag2;
                  if (div_zero) begin
                     res_q <= opt[1] ? src1 : '1;
                     state <= ST_DONE;
                  end else if (div_ovf) begin
                     res_q <= opt[1] ? '0 : src1;
                     state <= ST_DONE;
                  end else begin
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (fast_mul) begin
                  res_q <= mul_res;
                  state <= ST_DONE;
               end else begin
                  acc_hi <= opt_q[2] ? div_rem_n : mul_hi_n;
                  acc_lo <= opt_q[2] ? div_q_n : mul_lo_n;
                  cnt    <= cnt + CW'(1);
                  if (cnt == CW'(XLEN-1)) begin
                     res_q <= step_res;
                     cnt   <= '0;
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060124_mdu.sv
// Directed-vector bench for ysyx_23060124_mdu (XLEN=32): results, latency, flush, backpressure, reset.
module tb_ysyx_23060124_mdu;

   localparam logic [2:0] T_MUL    = 3'b000;
   localparam logic [2:0] T_MULH   = 3'b001;
   localparam logic [2:0] T_MULHSU = 3'b010;
   localparam logic [2:0] T_MULHU  = 3'b011;
   localparam logic [2:0] T_DIV    = 3'b100;
   localparam logic [2:0] T_DIVU   = 3'b101;
   localparam logic [2:0] T_REM    = 3'b110;
   localparam logic [2:0] T_REMU   = 3'b111;

`ifdef YSYX_23060124_MDU_FASTMUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic [2:0]  opt = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] res;

   int checks = 0;
   int errors = 0;

   ysyx_23060124_mdu #(.XLEN(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .src1      (src1),
      .src2      (src2),
      .opt       (opt),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request, scramble inputs after accept, wait for the result, then consume it.
   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
      int lat;
      @(negedge clock);
      chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1;
      opt      = op;
      src1     = a;
      src2     = b;
      @(negedge clock);
      in_valid = 1'b0;
      src1     = $urandom;
      src2     = $urandom;
      opt      = 3'($urandom);
      lat      = 1;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(negedge clock);
         lat++;
      end
      chk({tag, ".latency"}, 32'(lat), 32'(lat_exp));
      chk({tag, ".res"}, res, exp);
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      chk({tag, ".out_valid_drop"}, {31'b0, out_valid}, 32'd0);
      chk({tag, ".in_ready_back"}, {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      int xfers;
      int lat;

      #2 reset = 1'b1;
      #2;
      chk("reset.out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset.in_ready", {31'b0, in_ready}, 32'd1);
      chk("reset.res", res, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("post_reset.in_ready", {31'b0, in_ready}, 32'd1);
      chk("post_reset.out_valid", {31'b0, out_valid}, 32'd0);

      do_op("mulh_minmin", T_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
      do_op("mul_7xm3", T_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
      do_op("mulhu_max", T_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
      do_op("mulhsu_m1", T_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
      do_op("div_by0", T_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      do_op("remu_by0", T_REMU, 32'd5, 32'd0, 32'h0000_0005, 1);
      do_op("div_ovf", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      do_op("rem_ovf", T_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
      do_op("div_m7_2", T_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
      do_op("rem_m7_2", T_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
      do_op("divu_m7_2", T_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, DIV_LAT);
      do_op("remu_100_7", T_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);

      // Flush partway through a divide.
      @(negedge clock);
      in_valid = 1'b1; opt = T_DIV; src1 = 32'd100; src2 = 32'd7;
      @(negedge clock);
      in_valid = 1'b0;
      repeat (9) @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      chk("flush.in_ready", {31'b0, in_ready}, 32'd1);
      chk("flush.out_valid", {31'b0, out_valid}, 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clock);
         if (out_valid) seen++;
      end
      chk("flush.no_result", 32'(seen), 32'd0);
      do_op("after_flush", T_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);

      // Backpressure: result must hold while out_ready stays low.
      @(negedge clock);
      in_valid = 1'b1; opt = T_DIV; src1 = 32'hFFFF_FFF9; src2 = 32'd2;
      @(negedge clock);
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(negedge clock);
         lat++;
      end
      chk("bp.latency", 32'(lat), 32'(DIV_LAT));
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("bp.res_hold", res, 32'hFFFF_FFFD);
         chk("bp.out_valid_hold", {31'b0, out_valid}, 32'd1);
         chk("bp.in_ready_low", {31'b0, in_ready}, 32'd0);
      end
      xfers = 0;
      out_ready = 1'b1;
      repeat (3) begin
         if (out_valid && out_ready) xfers++;
         @(negedge clock);
      end
      out_ready = 1'b0;
      chk("bp.single_transfer", 32'(xfers), 32'd1);
      chk("bp.in_ready_after", {31'b0, in_ready}, 32'd1);

      // Reset in the middle of an operation drops it.
      @(negedge clock);
      in_valid = 1'b1; opt = T_DIV; src1 = 32'd100; src2 = 32'd7;
      @(negedge clock);
      in_valid = 1'b0;
      repeat (5) @(negedge clock);
      #1 reset = 1'b1;
      #1;
      chk("midreset.out_valid", {31'b0, out_valid}, 32'd0);
      chk("midreset.in_ready", {31'b0, in_ready}, 32'd1);
      chk("midreset.res", res, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clock);
         if (out_valid) seen++;
      end
      chk("midreset.no_result", 32'(seen), 32'd0);
      do_op("after_reset", T_REM, 32'd100, 32'd7, 32'd2, DIV_LAT);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
